// File: rtl/amm_mem_pkg.sv
// Shared types and default constants for the dual-port Avalon-MM memory.
// rd_pipe_t is one slot of the read-return pipe: a valid flag and a data word.
package amm_mem_pkg;

  localparam int unsigned DATA_WIDTH_DFLT   = 64;
  localparam int unsigned ADDR_WIDTH_DFLT   = 10;
  localparam int unsigned READ_LATENCY_DFLT = 2;
  localparam int unsigned MAX_OUTST_DFLT    = 4;

  // Data field width of a pipe slot; narrower memories zero-extend into it.
  localparam int unsigned RD_PIPE_DW = DATA_WIDTH_DFLT;

  typedef struct packed {
    logic                  valid;
    logic [RD_PIPE_DW-1:0] data;
  } rd_pipe_t;

endpackage

// File: rtl/amm_mem_rd_pipe.sv
// Fixed-latency read-return shift register.
// Ports:
//   clk_i   - clock
//   arstn_i - asynchronous active-low reset; clears every slot (drops in-flight reads)
//   i_d     - slot entering the pipe (valid = read accepted this cycle)
//   o_q     - slot leaving the pipe LATENCY cycles later
module amm_mem_rd_pipe
  import amm_mem_pkg::*;
#(
  parameter int unsigned LATENCY = READ_LATENCY_DFLT
) (
  input  logic     clk_i,
  input  logic     arstn_i,
  input  rd_pipe_t i_d,
  output rd_pipe_t o_q
);

  rd_pipe_t r_stage [LATENCY];

  // Shift one slot per cycle; reset empties the pipe.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[LATENCY-1];

endmodule

// File: rtl/amm_dual_mem.sv
// Dual-port Avalon-MM memory slave: pipelined read port, byte-enabled write
// port, one shared word array, programmable back-pressure on both ports.
// Ports:
//   clk_i, arstn_i                  - clock, async active-low reset
//   rd_address_i/rd_read_i          - read request
//   rd_waitrequest_o                - read not accepted (stall, full, or in reset)
//   rd_readdata_o/rd_readdatavalid_o- read return, READ_LATENCY after accept
//   wr_address_i/wr_write_i/wr_writedata_i/wr_byteenable_i - write request
//   wr_waitrequest_o                - write not accepted (stall or in reset)
//   stall_rd_i/stall_wr_i           - external back-pressure
module amm_dual_mem
  import amm_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DFLT,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DFLT,
  parameter int unsigned BYTE_CNT        = DATA_WIDTH / 8,
  parameter int unsigned READ_LATENCY    = READ_LATENCY_DFLT,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTST_DFLT
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic [ADDR_WIDTH-1:0] rd_address_i,
  input  logic                  rd_read_i,
  output logic                  rd_waitrequest_o,
  output logic [DATA_WIDTH-1:0] rd_readdata_o,
  output logic                  rd_readdatavalid_o,
  input  logic [ADDR_WIDTH-1:0] wr_address_i,
  input  logic                  wr_write_i,
  input  logic [DATA_WIDTH-1:0] wr_writedata_i,
  input  logic [BYTE_CNT-1:0]   wr_byteenable_i,
  output logic                  wr_waitrequest_o,
  input  logic                  stall_rd_i,
  input  logic                  stall_wr_i
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Elaboration-time parameter sanity.
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("READ_LATENCY must be 1..4");
  end
  if (MAX_OUTSTANDING < READ_LATENCY) begin : g_bad_outst
    $error("MAX_OUTSTANDING must be >= READ_LATENCY");
  end
  if (DATA_WIDTH > RD_PIPE_DW || DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of 8 and fit the pipe slot");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_in_rst;
  logic [CNT_W-1:0]      r_outst;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  rd_pipe_t              w_pipe_in;
  rd_pipe_t              w_pipe_out;

  assign rd_waitrequest_o = stall_rd_i | (r_outst == CNT_W'(MAX_OUTSTANDING)) | r_in_rst;
  assign wr_waitrequest_o = stall_wr_i | r_in_rst;
  assign w_rd_acc         = rd_read_i & ~rd_waitrequest_o;
  assign w_wr_acc         = wr_write_i & ~wr_waitrequest_o;

  // Held high through reset and for the first edge after release.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_in_rst <= 1'b1;
    else          r_in_rst <= 1'b0;
  end

  // Reads accepted but not yet returned.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_outst <= '0;
    end else begin
      unique case ({w_rd_acc, w_pipe_out.valid})
        2'b10:   r_outst <= r_outst + CNT_W'(1);
        2'b01:   r_outst <= r_outst - CNT_W'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Byte-lane write; array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      for (int unsigned k = 0; k < BYTE_CNT; k++) begin
        if (wr_byteenable_i[k]) begin
          r_mem[wr_address_i][8*k +: 8] <= wr_writedata_i[8*k +: 8];
        end
      end
    end
  end

  // Array is sampled before the same-edge write lands, giving read-first behaviour.
  always_comb begin
    w_pipe_in       = '0;
    w_pipe_in.valid = w_rd_acc;
    w_pipe_in.data  = RD_PIPE_DW'(r_mem[rd_address_i]);
  end

  amm_mem_rd_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .i_d     (w_pipe_in),
    .o_q     (w_pipe_out)
  );

  assign rd_readdatavalid_o = w_pipe_out.valid;
  assign rd_readdata_o      = DATA_WIDTH'(w_pipe_out.data);

endmodule

// File: tb/tb_amm_dual_mem.sv
// Self-checking bench for amm_dual_mem (READ_LATENCY=4, MAX_OUTSTANDING=4).
module tb_amm_dual_mem;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;
  localparam int unsigned BC = 8;
  localparam int unsigned RL = 4;
  localparam int unsigned MO = 4;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic [AW-1:0] rd_address_i;
  logic          rd_read_i;
  logic          rd_waitrequest_o;
  logic [DW-1:0] rd_readdata_o;
  logic          rd_readdatavalid_o;
  logic [AW-1:0] wr_address_i;
  logic          wr_write_i;
  logic [DW-1:0] wr_writedata_i;
  logic [BC-1:0] wr_byteenable_i;
  logic          wr_waitrequest_o;
  logic          stall_rd_i;
  logic          stall_wr_i;

  amm_dual_mem #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .BYTE_CNT        (BC),
    .READ_LATENCY    (RL),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i              (clk_i),
    .arstn_i            (arstn_i),
    .rd_address_i       (rd_address_i),
    .rd_read_i          (rd_read_i),
    .rd_waitrequest_o   (rd_waitrequest_o),
    .rd_readdata_o      (rd_readdata_o),
    .rd_readdatavalid_o (rd_readdatavalid_o),
    .wr_address_i       (wr_address_i),
    .wr_write_i         (wr_write_i),
    .wr_writedata_i     (wr_writedata_i),
    .wr_byteenable_i    (wr_byteenable_i),
    .wr_waitrequest_o   (wr_waitrequest_o),
    .stall_rd_i         (stall_rd_i),
    .stall_wr_i         (stall_wr_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc++;

  // Capture every returned word with the cycle it appeared in.
  logic [DW-1:0] rx_data [$];
  int unsigned   rx_cyc  [$];
  always @(negedge clk_i) begin
    if (rd_readdatavalid_o) begin
      rx_data.push_back(rd_readdata_o);
      rx_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  // All tasks start and end at negedge+1.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BC-1:0] be);
    int n = 0;
    wr_address_i = a; wr_writedata_i = d; wr_byteenable_i = be; wr_write_i = 1'b1;
    while (wr_waitrequest_o && n < 50) begin step(); n++; end
    if (n >= 50) chk("write accept timeout", 64'(n), 64'(0));
    step();
    wr_write_i = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int unsigned acc_cyc);
    int n = 0;
    rd_address_i = a; rd_read_i = 1'b1;
    while (rd_waitrequest_o && n < 50) begin step(); n++; end
    if (n >= 50) chk("read accept timeout", 64'(n), 64'(0));
    acc_cyc = cyc;
    step();
    rd_read_i = 1'b0;
  endtask

  task automatic wait_rx(input int cnt);
    int n = 0;
    while (rx_data.size() < cnt && n < 60) begin step(); n++; end
    if (rx_data.size() < cnt) chk("readdatavalid timeout", 64'(rx_data.size()), 64'(cnt));
  endtask

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BC-1:0] be;
    logic [DW-1:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin : main
    int unsigned   acc;
    int            acc_n;
    int            n;
    logic          early_wait;
    logic          w_after4;
    logic          got4;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_burst [6];

    // Write/read vectors; a read's expectation follows from the writes above it.
    vecs[0]  = '{1'b1, 10'h010, 64'h0102030405060708, 8'hFF, 64'h0};
    vecs[1]  = '{1'b0, 10'h010, 64'h0, 8'h00, 64'h0102030405060708};
    vecs[2]  = '{1'b1, 10'h020, 64'h0, 8'hFF, 64'h0};
    vecs[3]  = '{1'b1, 10'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0};
    vecs[4]  = '{1'b0, 10'h020, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF};
    vecs[5]  = '{1'b1, 10'h040, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'h0};
    vecs[6]  = '{1'b1, 10'h040, 64'h5555_5555_5555_5555, 8'h00, 64'h0};
    vecs[7]  = '{1'b0, 10'h040, 64'h0, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA};
    vecs[8]  = '{1'b1, 10'h041, 64'h0, 8'hFF, 64'h0};
    vecs[9]  = '{1'b1, 10'h041, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 64'h0};
    vecs[10] = '{1'b0, 10'h041, 64'h0, 8'h00, 64'hFF00_0000_0000_00FF};
    vecs[11] = '{1'b1, 10'h3FF, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0};
    vecs[12] = '{1'b0, 10'h3FF, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[13] = '{1'b1, 10'h000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0};
    vecs[14] = '{1'b0, 10'h000, 64'h0, 8'h00, 64'h1122_3344_5566_7788};

    arstn_i = 1'b0;
    rd_address_i = '0; rd_read_i = 1'b0;
    wr_address_i = '0; wr_write_i = 1'b0; wr_writedata_i = '0; wr_byteenable_i = '0;
    stall_rd_i = 1'b0; stall_wr_i = 1'b0;

    // Reset hold and release.
    repeat (3) step();
    chk("rst rd_waitrequest", 64'(rd_waitrequest_o), 64'(1));
    chk("rst wr_waitrequest", 64'(wr_waitrequest_o), 64'(1));
    chk("rst readdatavalid", 64'(rd_readdatavalid_o), 64'(0));
    chk("rst readdata", rd_readdata_o, 64'h0);
    arstn_i = 1'b1;
    #1;
    chk("release rd_waitrequest first cycle", 64'(rd_waitrequest_o), 64'(1));
    chk("release wr_waitrequest first cycle", 64'(wr_waitrequest_o), 64'(1));
    step();
    chk("release rd_waitrequest next cycle", 64'(rd_waitrequest_o), 64'(0));
    chk("release wr_waitrequest next cycle", 64'(wr_waitrequest_o), 64'(0));
    chk("release readdatavalid", 64'(rx_data.size()), 64'(0));

    // Table: writes back-to-back, each read checked for data and latency.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      end else begin
        do_read(vecs[i].addr, acc);
        wait_rx(1);
        if (rx_data.size() > 0) begin
          chk($sformatf("vec%0d data", i), rx_data.pop_front(), vecs[i].exp);
          chk($sformatf("vec%0d latency", i), 64'(rx_cyc.pop_front()), 64'(acc + RL));
        end
      end
    end

    // Outstanding limit: 6 continuous reads from 0x3FC, wrapping to 0x000.
    a = 10'h3FC;
    for (int i = 0; i < 6; i++) begin
      d = {32'hA5A5_0000, 22'h0, a};
      exp_burst[i] = d;
      do_write(a, d, 8'hFF);
      a = a + 10'd1;
    end
    a = 10'h3FC;
    acc_n = 0; n = 0; early_wait = 1'b0; w_after4 = 1'b0; got4 = 1'b0;
    rd_address_i = a; rd_read_i = 1'b1;
    while (acc_n < 6 && n < 40) begin
      if (acc_n == 4 && !got4) begin
        w_after4 = rd_waitrequest_o;
        got4 = 1'b1;
      end
      if (!rd_waitrequest_o) begin
        acc_n++;
        a = a + 10'd1;
      end else if (acc_n < 4) begin
        early_wait = 1'b1;
      end
      step();
      rd_address_i = a;
      n++;
    end
    rd_read_i = 1'b0;
    chk("burst accepts", 64'(acc_n), 64'(6));
    chk("burst waitrequest before limit", 64'(early_wait), 64'(0));
    chk("burst waitrequest at limit", 64'(w_after4), 64'(1));
    wait_rx(6);
    if (rx_cyc.size() >= 4) chk("burst back-to-back valids", 64'(rx_cyc[3] - rx_cyc[0]), 64'(3));
    for (int i = 0; i < 6; i++) begin
      if (rx_data.size() > 0) chk($sformatf("burst word%0d", i), rx_data.pop_front(), exp_burst[i]);
    end
    rx_cyc.delete();

    // Same-cycle read and write to one address: read-first.
    do_write(10'h030, 64'h11, 8'hFF);
    rd_address_i = 10'h030; rd_read_i = 1'b1;
    wr_address_i = 10'h030; wr_writedata_i = 64'h22; wr_byteenable_i = 8'hFF; wr_write_i = 1'b1;
    chk("rw same cycle both accepted", 64'({rd_waitrequest_o, wr_waitrequest_o}), 64'(0));
    step();
    rd_read_i = 1'b0; wr_write_i = 1'b0;
    do_read(10'h030, acc);
    wait_rx(2);
    if (rx_data.size() > 0) chk("rw old word", rx_data.pop_front(), 64'h11);
    if (rx_data.size() > 0) chk("rw new word", rx_data.pop_front(), 64'h22);
    rx_cyc.delete();

    // Read stall with a read in flight: return still arrives on time.
    do_read(10'h010, acc);
    stall_rd_i = 1'b1;
    #1;
    chk("stall_rd waitrequest", 64'(rd_waitrequest_o), 64'(1));
    wait_rx(1);
    if (rx_data.size() > 0) begin
      chk("stall in-flight data", rx_data.pop_front(), 64'h0102030405060708);
      chk("stall in-flight latency", 64'(rx_cyc.pop_front()), 64'(acc + RL));
    end
    stall_rd_i = 1'b0;

    // Write stall: a held write is not taken while stalled.
    do_write(10'h050, 64'h5050, 8'hFF);
    stall_wr_i = 1'b1;
    wr_address_i = 10'h050; wr_writedata_i = 64'hBAD; wr_byteenable_i = 8'hFF; wr_write_i = 1'b1;
    #1;
    chk("stall_wr waitrequest", 64'(wr_waitrequest_o), 64'(1));
    step(); step();
    wr_write_i = 1'b0; stall_wr_i = 1'b0;
    do_read(10'h050, acc);
    wait_rx(1);
    if (rx_data.size() > 0) chk("stalled write ignored", rx_data.pop_front(), 64'h5050);
    rx_cyc.delete();

    // Reset with 3 reads in flight: none return; counter starts again at 0.
    rd_address_i = 10'h010; rd_read_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pre-reset accept%0d", i), 64'(rd_waitrequest_o), 64'(0));
      step();
    end
    rd_read_i = 1'b0;
    arstn_i = 1'b0;
    repeat (3) step();
    arstn_i = 1'b1;
    repeat (5) step();
    chk("dropped reads produce no valid", 64'(rx_data.size()), 64'(0));
    rd_address_i = 10'h010; rd_read_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post-reset accept%0d", i), 64'(rd_waitrequest_o), 64'(0));
      step();
    end
    rd_read_i = 1'b0;
    wait_rx(4);
    for (int i = 0; i < 4; i++) begin
      if (rx_data.size() > 0) chk($sformatf("post-reset word%0d", i), rx_data.pop_front(), 64'h0102030405060708);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
